// File: rtl/mult_accumulator.sv
// mult_accumulator
//   Sums unsigned products from the upstream array multiplier into frames
//   (dot-product style) and presents each frame's sum, term count and
//   overflow flag on a registered valid/ready output. This block holds the
//   first register stage after the multiplier array.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   in_valid/in_ready/in_product/in_last   product input beat stream
//   out_valid/out_ready                    result handshake
//   out_acc, out_count, out_overflow       frame sum, term count, overflow
//   busy           a frame is partially accumulated
//
// Build option:
//   MULT_ACCUMULATOR_SATURATE_EN  when defined, the accumulator clamps to
//                                 all-ones on overflow instead of wrapping.
module mult_accumulator #(
  parameter int BITS     = 64,
  parameter int ACC_BITS = 136,
  parameter int LEN_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*BITS-1:0]     in_product,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_BITS-1:0]   out_acc,
  output logic [LEN_BITS-1:0]   out_count,
  output logic                  out_overflow,
  output logic                  busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state, next_state;

  logic [ACC_BITS-1:0] acc;
  logic [LEN_BITS-1:0] count;
  logic                ovf;

  logic                accept;
  logic                close;
  logic [ACC_BITS-1:0] base_acc;
  logic [LEN_BITS-1:0] base_count;
  logic                base_ovf;
  logic [ACC_BITS:0]   sum;
  logic [ACC_BITS-1:0] new_acc;
  logic [LEN_BITS-1:0] new_count;
  logic                new_ovf;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ACCUM);

  // A beat in IDLE starts a fresh frame, so it adds to zero rather than
  // to whatever is held in acc.
  always_comb begin
    base_acc   = (state == IDLE) ? '0 : acc;
    base_count = (state == IDLE) ? '0 : count;
    base_ovf   = (state == IDLE) ? 1'b0 : ovf;
    sum        = {1'b0, base_acc} + {{(ACC_BITS + 1 - 2*BITS){1'b0}}, in_product};
    new_ovf    = base_ovf | sum[ACC_BITS];
`ifdef MULT_ACCUMULATOR_SATURATE_EN
    // Once overflow has occurred the sum stays pinned at full scale.
    new_acc    = new_ovf ? '1 : sum[ACC_BITS-1:0];
`else
    new_acc    = sum[ACC_BITS-1:0];
`endif
    new_count  = base_count + 1'b1;
    close      = in_last || (new_count == '1);
  end

  always_comb begin
    next_state = state;
    if (accept) begin
      next_state = close ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        acc   <= new_acc;
        count <= new_count;
        ovf   <= new_ovf;
      end
    end
  end

  // A closing beat has priority over a plain handshake: when both happen
  // in one cycle the register reloads and out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (accept && close) begin
      out_valid    <= 1'b1;
      out_acc      <= new_acc;
      out_count    <= new_count;
      out_overflow <= new_ovf;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator
//   Randomized and directed stimulus for mult_accumulator (BITS=8,
//   ACC_BITS=18, LEN_BITS=4) checked against a frame-level reference model
//   that keeps a running integer sum and a queue of completed frame results.
module tb_mult_accumulator;

  localparam int     BITS     = 8;
  localparam int     ACC_BITS = 18;
  localparam int     LEN_BITS = 4;
  localparam longint ACC_MOD  = 64'd1 << ACC_BITS;
  localparam int     MAX_LEN  = (1 << LEN_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [2*BITS-1:0]   in_product = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACC_BITS-1:0] out_acc;
  logic [LEN_BITS-1:0] out_count;
  logic                out_overflow;
  logic                busy;

  mult_accumulator #(
    .BITS(BITS),
    .ACC_BITS(ACC_BITS),
    .LEN_BITS(LEN_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_product(in_product),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc(out_acc),
    .out_count(out_count),
    .out_overflow(out_overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: running frame sum as a plain integer plus a queue of
  // finished frames waiting to be handed downstream.
  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } res_t;

  res_t   q[$];
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     m_ovf = 0;

  function automatic void model_beat(input longint p, input bit l);
    res_t r;
    if (m_cnt == 0) begin
      m_sum = 0;
      m_ovf = 0;
    end
    m_sum = m_sum + p;
    if (m_sum >= ACC_MOD) begin
      m_ovf = 1;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
      m_sum = ACC_MOD - 1;
`else
      m_sum = m_sum - ACC_MOD;
`endif
    end
    m_cnt++;
    if (l || m_cnt == MAX_LEN) begin
      r.acc = m_sum;
      r.cnt = m_cnt;
      r.ovf = m_ovf;
      q.push_back(r);
      m_cnt = 0;
      m_sum = 0;
      m_ovf = 0;
    end
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the
  // model by whatever handshakes occur at the coming edge.
  task automatic tick(input bit v, input logic [2*BITS-1:0] p, input bit l, output bit accepted);
    bit pending;
    in_valid   = v;
    in_product = p;
    in_last    = l;
    #3;
    pending = (q.size() != 0);
    check("out_valid", out_valid, pending);
    check("in_ready", in_ready, !pending || out_ready);
    check("busy", busy, m_cnt != 0);
    if (pending) begin
      check("out_acc", out_acc, q[0].acc);
      check("out_count", out_count, q[0].cnt);
      check("out_overflow", out_overflow, q[0].ovf);
      if (out_ready) void'(q.pop_front());
    end
    accepted = v && (!pending || out_ready);
    if (accepted) model_beat(p, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2*BITS-1:0] p, input bit l);
    bit a;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, p, l, a);
      if (a) return;
    end
    check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_cnt = 0;
    m_sum = 0;
    m_ovf = 0;
  endtask

  initial begin
    bit a;
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_overflow", out_overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Single-term frame, then hold the result for three cycles.
    out_ready = 1'b0;
    send(16'hFFFF, 1'b1);
    check("single_acc", out_acc, 'h0FFFF);
    check("single_count", out_count, 1);
    check("single_valid", out_valid, 1'b1);
    tick(1'b1, 16'h1234, 1'b0, a);   // stalled beat must not be taken
    check("held_not_accepted", a, 1'b0);
    idle(2);
    check("held_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    idle(1);

    // Multi-term frame.
    send(16'd100, 1'b0);
    check("multi_busy", busy, 1'b1);
    send(16'd200, 1'b0);
    send(16'd300, 1'b1);
    check("multi_acc", out_acc, 600);
    check("multi_count", out_count, 3);
    idle(1);

    // Overflow frame.
    for (int i = 0; i < 5; i++) send(16'hFFFF, i == 4);
`ifdef MULT_ACCUMULATOR_SATURATE_EN
    check("ovf_acc", out_acc, 'h3FFFF);
`else
    check("ovf_acc", out_acc, 'h0FFFB);
`endif
    check("ovf_flag", out_overflow, 1'b1);
    idle(1);

    // Forced close after the maximum frame length.
    for (int i = 0; i < MAX_LEN; i++) send(16'd1, 1'b0);
    check("forced_count", out_count, 15);
    check("forced_acc", out_acc, 15);
    send(16'd1, 1'b0);
    check("forced_next_busy", busy, 1'b1);
    send(16'd2, 1'b1);
    check("forced_next_count", out_count, 2);
    idle(1);

    // Back-to-back single-beat frames.
    send(16'd5, 1'b1);
    check("b2b_acc0", out_acc, 5);
    send(16'd7, 1'b1);
    check("b2b_acc1", out_acc, 7);
    check("b2b_valid1", out_valid, 1'b1);
    send(16'd9, 1'b1);
    check("b2b_acc2", out_acc, 9);
    idle(1);

    // Reset mid-frame discards the partial sum.
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    do_reset();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    send(16'd3, 1'b1);
    check("midrst_acc", out_acc, 3);
    check("midrst_count", out_count, 1);
    idle(1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [2*BITS-1:0] p;
      out_ready = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      tick($urandom_range(0, 2) != 0, p, $urandom_range(0, 4) == 0, a);
    end
    out_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
